// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_REACT = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [15:0] BCD_MAX              = 16'h9999;
    localparam int          DEFAULT_MIN_DELAY_MS = 250;

    // One decimal increment of a 4-digit BCD value with per-digit carry.
    // Wraps at 9999; callers that need saturation test BCD_MAX first.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, enable and saturation at 9999.
module reaction_timer_bcd_counter4
    import reaction_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] bcd
);

    // Count up by one decimal step per enable; stick at 9999.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bcd <= '0;
        end else if (en && (bcd != BCD_MAX)) begin
            bcd <= bcd_inc(bcd);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random start delay, time_out pulse, BCD reaction measurement
// and false-start detection.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int LFSR_W       = 7,
    parameter int MIN_DELAY_MS = DEFAULT_MIN_DELAY_MS,
    parameter int CNT_W        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_ms,
    input  logic              start_delay,
    input  logic [LFSR_W-1:0] lfsr_val,
    input  logic              button,
    output logic              time_out,
    output logic              false_start,
    output logic              result_valid,
    output logic [15:0]       result_bcd,
    output logic              busy
);

    state_t           state;
    logic             start_q;
    logic             start_rise;
    logic [CNT_W-1:0] cnt;
    logic             react_tick;

    // Rising edge of the start request and the qualified reaction tick.
    // A button in the same cycle as a tick ends the run without counting it.
    always_comb begin
        start_rise = start_delay & ~start_q;
        react_tick = (state == ST_REACT) & tick_ms & ~button & ~start_rise;
    end

    // Reaction time counter; cleared at the start of every run.
    reaction_timer_bcd_counter4 u_bcd (
        .clk (clk),
        .rst (rst),
        .clr (start_rise),
        .en  (react_tick),
        .bcd (result_bcd)
    );

    // Control FSM with start edge register, delay down-counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            cnt          <= '0;
            time_out     <= 1'b0;
            false_start  <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            start_q  <= start_delay;
            time_out <= 1'b0;
            if (start_rise) begin
                state        <= ST_ARM;
                false_start  <= 1'b0;
                result_valid <= 1'b0;
                busy         <= 1'b1;
            end else begin
                case (state)
                    ST_ARM: begin
                        cnt   <= CNT_W'(lfsr_val) + CNT_W'(MIN_DELAY_MS);
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (button) begin
                            state       <= ST_FAULT;
                            false_start <= 1'b1;
                            time_out    <= 1'b1;
                            busy        <= 1'b0;
                        end else if (tick_ms) begin
                            cnt <= cnt - 1'b1;
                            if (cnt <= CNT_W'(1)) begin
                                state    <= ST_REACT;
                                time_out <= 1'b1;
                            end
                        end
                    end
                    ST_REACT: begin
                        if (button) begin
                            state        <= ST_DONE;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                    default: begin
                        // IDLE, DONE and FAULT hold until the next start or reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed self-checking bench for reaction_timer; tick_ms every 4 clocks.
`timescale 1ns/1ps
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_ms;
    logic        start_delay;
    logic [6:0]  lfsr_val;
    logic        button;
    logic        time_out;
    logic        false_start;
    logic        result_valid;
    logic [15:0] result_bcd;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int to_cnt = 0;
    int busy_low = 0;
    logic watch_busy = 1'b0;

    reaction_timer #(
        .LFSR_W       (7),
        .MIN_DELAY_MS (250),
        .CNT_W        (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_ms      (tick_ms),
        .start_delay  (start_delay),
        .lfsr_val     (lfsr_val),
        .button       (button),
        .time_out     (time_out),
        .false_start  (false_start),
        .result_valid (result_valid),
        .result_bcd   (result_bcd),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Observe pulse count and busy drop-outs away from the active edge.
    always @(negedge clk) begin
        if (time_out) to_cnt++;
        if (watch_busy && !busy) busy_low++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One ms period: tick on the first clock, optional button with that tick.
    task automatic ms_period(input logic btn);
        tick_ms = 1'b1;
        button  = btn;
        step();
        tick_ms = 1'b0;
        button  = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic ms_periods(input int n);
        for (int i = 0; i < n; i++) ms_period(1'b0);
    endtask

    task automatic start_run(input logic [6:0] lv);
        lfsr_val    = lv;
        start_delay = 1'b1;
        step();
        start_delay = 1'b0;
        step();
    endtask

    initial begin
        int t0;
        rst = 1'b1; tick_ms = 1'b0; start_delay = 1'b0; lfsr_val = '0; button = 1'b0;
        step();
        check_val("rst_time_out", {31'd0, time_out}, 32'd0);
        check_val("rst_flags", {29'd0, false_start, result_valid, busy}, 32'd0);
        check_val("rst_bcd", {16'd0, result_bcd}, 32'd0);
        rst = 1'b0;
        step();

        // 1. delay of 10+250 ticks
        start_run(7'd10);
        check_val("t1_busy_arm", {31'd0, busy}, 32'd1);
        watch_busy = 1'b1;
        t0 = to_cnt;
        ms_periods(259);
        check_val("t1_no_early_to", to_cnt - t0, 32'd0);
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
        check_val("t1_to_after_260", {31'd0, time_out}, 32'd1);
        step(); step(); step();
        check_val("t1_to_one_cycle", to_cnt - t0, 32'd1);

        // 2. button after the 123rd reaction tick
        ms_periods(123);
        check_val("t2_live_bcd", {16'd0, result_bcd}, 32'h0123);
        check_val("t2_busy_held", busy_low, 32'd0);
        watch_busy = 1'b0;
        button = 1'b1;
        step();
        button = 1'b0;
        check_val("t2_bcd", {16'd0, result_bcd}, 32'h0123);
        check_val("t2_valid", {31'd0, result_valid}, 32'd1);
        check_val("t2_busy", {31'd0, busy}, 32'd0);
        ms_period(1'b1);
        ms_periods(5);
        check_val("t2_done_hold", {15'd0, result_valid, result_bcd}, 32'h1_0123);
        check_val("t2_single_to", to_cnt - t0, 32'd1);

        // 3. false start on the 100th WAIT tick (button beats tick)
        start_run(7'd0);
        check_val("t3_cleared", {14'd0, false_start, result_valid, result_bcd}, 32'd0);
        t0 = to_cnt;
        ms_periods(99);
        tick_ms = 1'b1;
        button  = 1'b1;
        step();
        tick_ms = 1'b0;
        button  = 1'b0;
        check_val("t3_to_pulse", {31'd0, time_out}, 32'd1);
        check_val("t3_false_start", {31'd0, false_start}, 32'd1);
        ms_periods(300);
        check_val("t3_single_to", to_cnt - t0, 32'd1);
        check_val("t3_hold", {29'd0, false_start, result_valid, busy}, 32'd4);
        check_val("t3_no_count", {16'd0, result_bcd}, 32'd0);

        // 4. saturation at 9999
        start_run(7'd0);
        ms_periods(250);
        ms_periods(1000);
        check_val("t4_carry_1000", {16'd0, result_bcd}, 32'h1000);
        ms_periods(8999);
        check_val("t4_reach_9999", {16'd0, result_bcd}, 32'h9999);
        ms_periods(6);
        check_val("t4_saturate", {16'd0, result_bcd}, 32'h9999);
        check_val("t4_state_react", {30'd0, result_valid, busy}, 32'd1);

        // 5. reset mid-WAIT
        start_run(7'd0);
        t0 = to_cnt;
        ms_periods(200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_rst_outputs", {12'd0, time_out, false_start, result_valid, busy, result_bcd}, 32'd0);
        ms_periods(300);
        check_val("t5_no_to", to_cnt - t0, 32'd0);
        check_val("t5_idle", {31'd0, busy}, 32'd0);
        start_run(7'd5);
        ms_periods(254);
        check_val("t5_no_early_to", to_cnt - t0, 32'd0);
        ms_period(1'b0);
        check_val("t5_to_after_255", to_cnt - t0, 32'd1);

        // 6. tick and button in the same cycle at count 0042
        ms_periods(42);
        ms_period(1'b1);
        check_val("t6_bcd", {16'd0, result_bcd}, 32'h0042);
        check_val("t6_valid", {31'd0, result_valid}, 32'd1);
        start_delay = 1'b1;
        button      = 1'b1;
        step();
        start_delay = 1'b0;
        button      = 1'b0;
        check_val("t6_arm", {13'd0, busy, false_start, result_valid, result_bcd}, 32'h4_0000);
        step();
        ms_periods(3);
        check_val("t6_no_false", {29'd0, false_start, time_out, busy}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
